// File: rtl/uart_mem_bridge.sv
// Host byte-stream bridge: loads words into memory from UART frames, dumps memory back, ACK/NAKs writes.
// Latency: 2 cycles per write chunk; 1 + RD_LAT cycles per dump word read, then 1+ cycle per TX byte.
// Backpressure: TX bytes advance only on tx_valid & tx_ready; RX bytes arriving while busy are dropped and flagged.
module uart_mem_bridge #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 12,
    parameter int CHUNK_W = 6,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr_data,
    output logic              mem_rw,
    output logic              mem_commit,
    input  logic [DATA_W-1:0] mem_result,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_frame
);

    localparam int AB     = (ADDR_W + 5) / 6;
    localparam int DB     = (DATA_W + 5) / 6;
    localparam int AF     = AB * 6;
    localparam int DF     = DB * 6;
    localparam int PW     = AF + DF;
    localparam int RW     = DF + ADDR_W;
    localparam int NB     = AB + DB;
    localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int CPW    = NCHUNK * CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W  = $clog2(NB + 1);
    localparam int WC_W   = $clog2(RD_LAT + 1);
    localparam int SW     = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

    localparam logic [7:0] B_START = 8'hF5;
    localparam logic [7:0] B_WRITE = 8'hFA;
    localparam logic [7:0] B_DALL  = 8'hF6;
    localparam logic [7:0] B_DRNG  = 8'hF7;
    localparam logic [7:0] R_ACK   = 8'hA5;
    localparam logic [7:0] R_NAK   = 8'hE5;
    localparam logic [7:0] R_END   = 8'hFB;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, COLLECT, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_BYTES, TX_RESP
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [RW-1:0]     payload;
    logic [IDX_W-1:0]  chunk_idx;
    logic [ADDR_W-1:0] dump_addr;
    logic [ADDR_W-1:0] dump_end;
    logic [WC_W-1:0]   wait_cnt;
    logic [PW-1:0]     tx_sreg;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        resp;

    // Payload register keeps only the bits that land in the address and data fields.
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic [CPW-1:0]    data_pad;
    logic [CHUNK_W-1:0] chunk;
    logic [ADDR_W-1:0] wr_word;
    logic [SW-1:0]     rng_sum;
    logic [ADDR_W-1:0] rng_end;

    assign frame_addr = payload[RW-1:DF];
    assign frame_data = payload[DATA_W-1:0];
    assign data_pad   = CPW'(frame_data);
    assign chunk      = data_pad[chunk_idx*CHUNK_W +: CHUNK_W];
    assign wr_word    = (ADDR_W'(chunk_idx) << CHUNK_W) | ADDR_W'(chunk);
    assign rng_sum    = SW'(frame_addr) + SW'(frame_data);
    assign rng_end    = (rng_sum > SW'(ADDR_MAX)) ? ADDR_MAX : rng_sum[ADDR_W-1:0];

    logic idle_like, rx_take, is_payload, is_cmd, frame_full;
    logic do_start, do_write, do_dump_all, do_dump_rng, do_nak, do_shift, do_err;
    logic tx_fire, rd_done, tx_last, dump_last, wr_last;

    assign idle_like   = (state == IDLE) || (state == COLLECT);
    assign rx_take     = rx_valid && idle_like;
    assign is_payload  = (rx_data[7:6] == 2'b00);
    assign is_cmd      = (rx_data == B_START) || (rx_data == B_WRITE) ||
                         (rx_data == B_DALL)  || (rx_data == B_DRNG);
    assign frame_full  = (state == COLLECT) && (cnt == CNT_W'(NB));
    assign do_start    = rx_take && (rx_data == B_START);
    assign do_write    = rx_take && (rx_data == B_WRITE) && frame_full;
    assign do_dump_all = rx_take && (rx_data == B_DALL);
    assign do_dump_rng = rx_take && (rx_data == B_DRNG) && frame_full;
    assign do_nak      = rx_take && ((rx_data == B_WRITE) || (rx_data == B_DRNG)) && !frame_full;
    assign do_shift    = rx_take && is_payload && (state == COLLECT) && (cnt < CNT_W'(NB));
    assign do_err      = rx_take && !is_cmd && !do_shift;

    assign tx_fire   = ((state == TX_BYTES) || (state == TX_RESP)) && tx_ready;
    assign rd_done   = (state == RD_WAIT) && (wait_cnt == WC_W'(RD_LAT - 1));
    assign tx_last   = (state == TX_BYTES) && tx_ready && (byte_cnt == CNT_W'(NB - 1));
    assign dump_last = (dump_addr == dump_end);
    assign wr_last   = (state == WR_DATA) && (chunk_idx == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        mem_own       = 1'b0;
        mem_addr_data = '0;
        mem_rw        = 1'b1;
        mem_commit    = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE, COLLECT: begin
                busy = 1'b0;
                if (do_start)                        state_nxt = COLLECT;
                else if (do_write)                   state_nxt = WR_ADDR;
                else if (do_dump_all || do_dump_rng) state_nxt = RD_ADDR;
                else if (do_nak)                     state_nxt = TX_RESP;
                else if (do_err)                     state_nxt = IDLE;
            end
            WR_ADDR: begin
                mem_own       = 1'b1;
                mem_addr_data = frame_addr;
                mem_rw        = 1'b0;
                state_nxt     = WR_DATA;
            end
            WR_DATA: begin
                mem_own       = 1'b1;
                mem_addr_data = wr_word;
                mem_rw        = 1'b0;
                mem_commit    = 1'b1;
                state_nxt     = wr_last ? TX_RESP : WR_ADDR;
            end
            RD_ADDR: begin
                mem_own       = 1'b1;
                mem_addr_data = dump_addr;
                state_nxt     = RD_WAIT;
            end
            RD_WAIT: begin
                // Address stays on the bus until the word is captured.
                mem_own       = 1'b1;
                mem_addr_data = dump_addr;
                if (rd_done) state_nxt = TX_BYTES;
            end
            TX_BYTES: begin
                mem_own  = 1'b1;
                tx_valid = 1'b1;
                tx_data  = {2'b00, tx_sreg[PW-1 -: 6]};
                if (tx_last) state_nxt = dump_last ? TX_RESP : RD_ADDR;
            end
            TX_RESP: begin
                tx_valid = 1'b1;
                tx_data  = resp;
                if (tx_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            payload     <= '0;
            chunk_idx   <= '0;
            dump_addr   <= '0;
            dump_end    <= '0;
            wait_cnt    <= '0;
            tx_sreg     <= '0;
            byte_cnt    <= '0;
            resp        <= 8'h00;
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            if (do_start) begin
                cnt         <= '0;
                err_overrun <= 1'b0;
                err_frame   <= 1'b0;
            end
            if (do_shift) begin
                payload <= {payload[RW-7:0], rx_data[5:0]};
                cnt     <= cnt + CNT_W'(1);
            end
            if (do_err)                err_frame   <= 1'b1;
            if (rx_valid && !idle_like) err_overrun <= 1'b1;
            if (do_nak)                resp        <= R_NAK;

            if (do_write)                 chunk_idx <= '0;
            if (state == WR_DATA && !wr_last) chunk_idx <= chunk_idx + IDX_W'(1);
            if (wr_last)                  resp      <= R_ACK;

            if (do_dump_all) begin
                dump_addr <= '0;
                dump_end  <= ADDR_MAX;
            end
            if (do_dump_rng) begin
                dump_addr <= frame_addr;
                dump_end  <= rng_end;
            end

            if (state == RD_ADDR)            wait_cnt <= '0;
            if (state == RD_WAIT && !rd_done) wait_cnt <= wait_cnt + WC_W'(1);
            if (rd_done) begin
                tx_sreg  <= {AF'(dump_addr), DF'(mem_result)};
                byte_cnt <= '0;
            end

            if (state == TX_BYTES && tx_ready) begin
                tx_sreg  <= tx_sreg << 6;
                byte_cnt <= byte_cnt + CNT_W'(1);
                if (tx_last && !dump_last) dump_addr <= dump_addr + ADDR_W'(1);
                if (tx_last && dump_last)  resp      <= R_END;
            end
        end
    end

endmodule
